// File: rtl/lsr_seq4.sv
// lsr_seq4: multi-pass 4-bit logical-shift-right engine.
// Splits a 0-7 shift amount into passes of at most 3. Each pass goes
// through one combinational LSR4 stage per clock. Operands are accepted
// and results are returned over valid/ready handshakes.
// Optional build macro: LSR_SEQ_FASTZERO_EN. When it is defined, a remaining
// shift of 4 or more resolves straight to zero in a single SHIFT cycle.

// Combinational 4-bit logical shift right by 0..3 with zero fill.
module lsr4 (
  input  logic [3:0] a,
  input  logic [1:0] sh,
  output logic [3:0] y
);
  assign y = a >> sh;
endmodule

module lsr_seq4 (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic [3:0] I,
  input  logic [2:0] S,
  input  logic       I_valid,
  output logic       I_ready,
  output logic [3:0] O,
  output logic       O_valid,
  input  logic       O_ready,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] d_q, d_d;
  logic [2:0] r_q, r_d;
  logic [3:0] o_q, o_d;

  logic [2:0] pass_amt;
  logic [2:0] r_rem;
  logic [3:0] lsr_out;
  logic       fast_zero;

  // Per-pass amount is min(R,3), so R can never underflow.
  assign pass_amt = (r_q > 3'd3) ? 3'd3 : r_q;
  assign r_rem    = r_q - pass_amt;

`ifdef LSR_SEQ_FASTZERO_EN
  assign fast_zero = (r_q >= 3'd4);
`else
  assign fast_zero = 1'b0;
`endif

  lsr4 u_lsr4 (
    .a  (d_q),
    .sh (pass_amt[1:0]),
    .y  (lsr_out)
  );

  assign I_ready = (state_q == IDLE);
  assign O_valid = (state_q == DONE);
  assign BUSY    = (state_q != IDLE);
  assign O       = o_q;

  // Next-state and datapath: accept in IDLE, one pass per SHIFT cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    r_d     = r_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (I_valid) begin
          d_d = I;
          r_d = S;
          if (S == 3'd0) begin
            o_d     = I;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (fast_zero) begin
          d_d     = 4'd0;
          r_d     = 3'd0;
          o_d     = 4'd0;
          state_d = DONE;
        end else begin
          d_d = lsr_out;
          r_d = r_rem;
          if (r_rem == 3'd0) begin
            o_d     = lsr_out;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (O_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers, cleared asynchronously on reset.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      d_q     <= 4'd0;
      r_q     <= 3'd0;
      o_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      o_q     <= o_d;
    end
  end

endmodule

// File: tb/tb_lsr_seq4.sv
// Directed testbench for lsr_seq4. Expected values are hand-computed.
// The S>=4 timing expectations follow LSR_SEQ_FASTZERO_EN when it is defined.
module tb_lsr_seq4;

  logic       CLK;
  logic       ASYNCRESETN;
  logic [3:0] I;
  logic [2:0] S;
  logic       I_valid;
  logic       I_ready;
  logic [3:0] O;
  logic       O_valid;
  logic       O_ready;
  logic       BUSY;

  int vectors;
  int miscompares;

  lsr_seq4 dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I           (I),
    .S           (S),
    .I_valid     (I_valid),
    .I_ready     (I_ready),
    .O           (O),
    .O_valid     (O_valid),
    .O_ready     (O_ready),
    .BUSY        (BUSY)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive all handshake and data inputs at once.
  task automatic applyStimulus(input logic [3:0] i_v, input logic [2:0] s_v,
                               input logic valid_v, input logic ordy_v);
    I       = i_v;
    S       = s_v;
    I_valid = valid_v;
    O_ready = ordy_v;
  endtask

  // Advance one rising edge and settle 1 unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compare every observable output against expected values.
  task automatic checkOutput(input string tag, input logic [3:0] e_o,
                             input logic e_ov, input logic e_ir, input logic e_busy);
    vectors++;
    assert (O === e_o) else begin
      miscompares++;
      $error("[TB] FAIL %s O: got %b expected %b", tag, O, e_o);
    end
    vectors++;
    assert (O_valid === e_ov) else begin
      miscompares++;
      $error("[TB] FAIL %s O_valid: got %b expected %b", tag, O_valid, e_ov);
    end
    vectors++;
    assert (I_ready === e_ir) else begin
      miscompares++;
      $error("[TB] FAIL %s I_ready: got %b expected %b", tag, I_ready, e_ir);
    end
    vectors++;
    assert (BUSY === e_busy) else begin
      miscompares++;
      $error("[TB] FAIL %s BUSY: got %b expected %b", tag, BUSY, e_busy);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    vectors     = 0;
    miscompares = 0;
    ASYNCRESETN = 1'b0;
    applyStimulus(4'b0000, 3'd0, 1'b0, 1'b0);

    // Reset held for two cycles, then released.
    tick();
    tick();
    checkOutput("reset_held", 4'b0000, 1'b0, 1'b1, 1'b0);
    ASYNCRESETN = 1'b1;
    tick();
    checkOutput("reset_idle", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Zero shift passes straight to DONE.
    applyStimulus(4'b1011, 3'd0, 1'b1, 1'b1);
    tick();
    checkOutput("zero_done", 4'b1011, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 3'd0, 1'b0, 1'b1);
    tick();
    checkOutput("zero_idle", 4'b1011, 1'b0, 1'b1, 1'b0);

    // S=7 with 1111: passes of 3,3,1 give 0000.
    applyStimulus(4'b1111, 3'd7, 1'b1, 1'b0);
    tick();
    checkOutput("s7_shift1", 4'b1011, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0101, 3'd1, 1'b0, 1'b0);
    tick();
`ifdef LSR_SEQ_FASTZERO_EN
    checkOutput("s7_fast_done", 4'b0000, 1'b1, 1'b0, 1'b1);
`else
    checkOutput("s7_shift2", 4'b1011, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("s7_shift3", 4'b1011, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("s7_done", 4'b0000, 1'b1, 1'b0, 1'b1);
`endif
    O_ready = 1'b1;
    tick();
    checkOutput("s7_idle", 4'b0000, 1'b0, 1'b1, 1'b0);

    // S=3 is a single pass: 1000 -> 0001.
    applyStimulus(4'b1000, 3'd3, 1'b1, 1'b1);
    tick();
    checkOutput("s3_shift", 4'b0000, 1'b0, 1'b0, 1'b1);
    I_valid = 1'b0;
    tick();
    checkOutput("s3_done", 4'b0001, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("s3_idle", 4'b0001, 1'b0, 1'b1, 1'b0);

    // Backpressure: result held, new operand on I_valid not accepted in DONE.
    applyStimulus(4'b1100, 3'd2, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b1111, 3'd0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_hold", 4'b0011, 1'b1, 1'b0, 1'b1);
      tick();
    end
    O_ready = 1'b1;
    tick();
    checkOutput("bp_release", 4'b0011, 1'b0, 1'b1, 1'b0);
    I_valid = 1'b0;
    tick();
    checkOutput("bp_no_accept", 4'b0011, 1'b0, 1'b1, 1'b0);

    // Input changes during SHIFT do not disturb the captured operand.
    applyStimulus(4'b1110, 3'd2, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b0001, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("stable_done", 4'b0011, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 3'd0, 1'b0, 1'b1);
    tick();
    checkOutput("stable_idle", 4'b0011, 1'b0, 1'b1, 1'b0);

    // Reset during the second SHIFT cycle of S=7 aborts with no output.
    applyStimulus(4'b1111, 3'd7, 1'b1, 1'b1);
    tick();
    I_valid = 1'b0;
    tick();
    ASYNCRESETN = 1'b0;
    #1;
    checkOutput("abort_now", 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("abort_held", 4'b0000, 1'b0, 1'b1, 1'b0);
    ASYNCRESETN = 1'b1;
    applyStimulus(4'b0110, 3'd1, 1'b1, 1'b0);
    tick();
    checkOutput("post_reset_accept", 4'b0000, 1'b0, 1'b0, 1'b1);
    I_valid = 1'b0;
    tick();
    checkOutput("post_reset_done", 4'b0011, 1'b1, 1'b0, 1'b1);
    O_ready = 1'b1;
    tick();
    checkOutput("post_reset_idle", 4'b0011, 1'b0, 1'b1, 1'b0);

    // S=5 with 1011 resolves to zero; latency depends on the build.
    applyStimulus(4'b1011, 3'd5, 1'b1, 1'b1);
    tick();
    I_valid = 1'b0;
    checkOutput("s5_shift1", 4'b0011, 1'b0, 1'b0, 1'b1);
    tick();
`ifndef LSR_SEQ_FASTZERO_EN
    checkOutput("s5_shift2", 4'b0011, 1'b0, 1'b0, 1'b1);
    tick();
`endif
    checkOutput("s5_done", 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("s5_idle", 4'b0000, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
